// File: rtl/xge_tx_arbiter.sv
// Packet-atomic round-robin arbiter in front of the XGE MAC transmit interface.
// A grant is held from SOP to EOP; non-SOP beats seen while idle are drained
// and counted so a source that lost framing cannot block the link.
module xge_tx_arbiter #(
    parameter int unsigned N      = 2,
    parameter int unsigned DROP_W = 16
) (
    input  logic              clk_156m25,
    input  logic              reset_156m25_n,
    input  logic              arb_en,
    input  logic [N-1:0]      src_val,
    input  logic [N-1:0]      src_sop,
    input  logic [N-1:0]      src_eop,
    input  logic [3*N-1:0]    src_mod,
    input  logic [64*N-1:0]   src_data,
    output logic [N-1:0]      src_ready,
    output logic [63:0]       pkt_tx_data,
    output logic              pkt_tx_val,
    output logic              pkt_tx_sop,
    output logic              pkt_tx_eop,
    output logic [2:0]        pkt_tx_mod,
    input  logic              pkt_tx_full,
    output logic [N-1:0]      cur_grant,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
    // Wide enough to hold a per-cycle drop count of up to N.
    localparam int unsigned CntW = IdxW + 1;

    typedef enum logic [0:0] {
        StIdle,
        StXfer
    } state_e;

    state_e            state_q;
    logic [IdxW-1:0]   last_grant_q;
    logic [N-1:0]      cur_grant_q;
    logic [DROP_W-1:0] drop_cnt_q;
    logic [DROP_W-1:0] drop_cnt_d;
    logic [63:0]       out_data_q;
    logic              out_val_q;
    logic              out_sop_q;
    logic              out_eop_q;
    logic [2:0]        out_mod_q;

    logic [N-1:0]      eligible;
    logic [N-1:0]      junk;
    logic              pick_found;
    logic [IdxW-1:0]   pick_idx;
    logic [N-1:0]      pick_onehot;
    logic [IdxW-1:0]   grant_idx;
    logic              g_val;
    logic              g_sop;
    logic              g_eop;
    logic [2:0]        g_mod;
    logic [63:0]       g_data;
    logic              xfer_accept;
    logic [CntW-1:0]   junk_cnt;

    assign eligible = src_val & src_sop;
    assign junk     = src_val & ~src_sop;

    // Ready: drain stray beats while idle, follow MAC back-pressure for the owner.
    // Held low during reset so no beat is handed off uncounted.
    always_comb begin
        src_ready = '0;
        if (reset_156m25_n) begin
            case (state_q)
                StIdle:  src_ready = junk;
                StXfer:  src_ready = pkt_tx_full ? '0 : cur_grant_q;
                default: src_ready = '0;
            endcase
        end
    end

    // Round-robin pick: first eligible index searching upward from last_grant+1.
    always_comb begin
        int unsigned cand;
        pick_found  = 1'b0;
        pick_idx    = '0;
        pick_onehot = '0;
        cand        = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = (32'(last_grant_q) + k) % N;
            if (!pick_found && eligible[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand[IdxW-1:0];
            end
        end
        pick_onehot[pick_idx] = 1'b1;
    end

    // Select the granted source's beat; cur_grant_q is one-hot so OR-select works.
    always_comb begin
        g_val     = 1'b0;
        g_sop     = 1'b0;
        g_eop     = 1'b0;
        g_mod     = '0;
        g_data    = '0;
        grant_idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (cur_grant_q[i]) begin
                grant_idx = IdxW'(i);
                g_val     = src_val[i];
                g_sop     = src_sop[i];
                g_eop     = src_eop[i];
                g_mod     = src_mod[3*i +: 3];
                g_data    = src_data[64*i +: 64];
            end
        end
    end

    assign xfer_accept = (state_q == StXfer) & g_val & ~pkt_tx_full;

    // Saturating drop counter: adds the number of beats drained this idle cycle.
    always_comb begin
        logic [DROP_W+CntW-1:0] sum;
        junk_cnt = '0;
        for (int unsigned i = 0; i < N; i++) begin
            junk_cnt = junk_cnt + CntW'(junk[i]);
        end
        sum        = {{CntW{1'b0}}, drop_cnt_q} + {{DROP_W{1'b0}}, junk_cnt};
        drop_cnt_d = drop_cnt_q;
        if (state_q == StIdle) begin
            if (|sum[DROP_W+CntW-1:DROP_W]) begin
                drop_cnt_d = '1;
            end else begin
                drop_cnt_d = sum[DROP_W-1:0];
            end
        end
    end

    // Arbiter FSM with registered MAC-side outputs.
    always_ff @(posedge clk_156m25) begin
        if (!reset_156m25_n) begin
            state_q      <= StIdle;
            last_grant_q <= IdxW'(N - 1);
            cur_grant_q  <= '0;
            drop_cnt_q   <= '0;
            out_data_q   <= '0;
            out_val_q    <= 1'b0;
            out_sop_q    <= 1'b0;
            out_eop_q    <= 1'b0;
            out_mod_q    <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
            out_val_q  <= 1'b0;
            out_sop_q  <= 1'b0;
            out_eop_q  <= 1'b0;
            out_mod_q  <= '0;
            case (state_q)
                StIdle: begin
                    if (arb_en && pick_found) begin
                        cur_grant_q <= pick_onehot;
                        state_q     <= StXfer;
                    end
                end
                StXfer: begin
                    if (xfer_accept) begin
                        out_val_q  <= 1'b1;
                        out_sop_q  <= g_sop;
                        out_eop_q  <= g_eop;
                        out_mod_q  <= g_eop ? g_mod : 3'd0;
                        out_data_q <= g_data;
                        if (g_eop) begin
                            last_grant_q <= grant_idx;
                            cur_grant_q  <= '0;
                            state_q      <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign pkt_tx_data = out_data_q;
    assign pkt_tx_val  = out_val_q;
    assign pkt_tx_sop  = out_sop_q;
    assign pkt_tx_eop  = out_eop_q;
    assign pkt_tx_mod  = out_mod_q;
    assign cur_grant   = cur_grant_q;
    assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_xge_tx_arbiter.sv
// Scoreboard bench for xge_tx_arbiter: stimulus pushes expected MAC beats,
// a monitor pops and compares whenever pkt_tx_val is high.
module tb_xge_tx_arbiter;

    localparam int unsigned N  = 2;
    localparam int unsigned DW = 16;

    logic            clk;
    logic            rst_n;
    logic            arb_en;
    logic [N-1:0]    src_val;
    logic [N-1:0]    src_sop;
    logic [N-1:0]    src_eop;
    logic [3*N-1:0]  src_mod;
    logic [64*N-1:0] src_data;
    logic [N-1:0]    src_ready;
    logic [63:0]     pkt_tx_data;
    logic            pkt_tx_val;
    logic            pkt_tx_sop;
    logic            pkt_tx_eop;
    logic [2:0]      pkt_tx_mod;
    logic            pkt_tx_full;
    logic [N-1:0]    cur_grant;
    logic [DW-1:0]   drop_cnt;

    // Second instance with a 2-bit drop counter for the saturation case.
    logic [N-1:0]    s_val;
    logic [N-1:0]    s_sop;
    logic [N-1:0]    s_ready;
    logic [63:0]     s_data_o;
    logic            s_val_o;
    logic            s_sop_o;
    logic            s_eop_o;
    logic [2:0]      s_mod_o;
    logic [N-1:0]    s_grant;
    logic [1:0]      s_drop;

    xge_tx_arbiter #(.N(N), .DROP_W(DW)) u_dut (
        .clk_156m25     (clk),
        .reset_156m25_n (rst_n),
        .arb_en         (arb_en),
        .src_val        (src_val),
        .src_sop        (src_sop),
        .src_eop        (src_eop),
        .src_mod        (src_mod),
        .src_data       (src_data),
        .src_ready      (src_ready),
        .pkt_tx_data    (pkt_tx_data),
        .pkt_tx_val     (pkt_tx_val),
        .pkt_tx_sop     (pkt_tx_sop),
        .pkt_tx_eop     (pkt_tx_eop),
        .pkt_tx_mod     (pkt_tx_mod),
        .pkt_tx_full    (pkt_tx_full),
        .cur_grant      (cur_grant),
        .drop_cnt       (drop_cnt)
    );

    xge_tx_arbiter #(.N(N), .DROP_W(2)) u_dut_sat (
        .clk_156m25     (clk),
        .reset_156m25_n (rst_n),
        .arb_en         (1'b1),
        .src_val        (s_val),
        .src_sop        (s_sop),
        .src_eop        ('0),
        .src_mod        ('0),
        .src_data       ('0),
        .src_ready      (s_ready),
        .pkt_tx_data    (s_data_o),
        .pkt_tx_val     (s_val_o),
        .pkt_tx_sop     (s_sop_o),
        .pkt_tx_eop     (s_eop_o),
        .pkt_tx_mod     (s_mod_o),
        .pkt_tx_full    (1'b0),
        .cur_grant      (s_grant),
        .drop_cnt       (s_drop)
    );

    typedef struct packed {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic [2:0]  mod;
    } beat_t;

    beat_t q0[$];
    beat_t q1[$];
    beat_t exp_q[$];
    int    total = 0;
    int    bad   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, expv);
        end
    endtask

    // Queue a packet on a source; the first n_exp beats are expected at the MAC.
    // Non-EOP beats carry mod=7 on the source side so leaking mod is visible.
    task automatic push_pkt(input int src, input int nb, input logic [2:0] m,
                            input logic [7:0] tag, input int n_exp);
        for (int b = 0; b < nb; b++) begin
            beat_t s;
            beat_t e;
            s.data = 64'hA500_0000_0000_0000 | (64'(tag) << 16) | 64'(b);
            s.sop  = (b == 0);
            s.eop  = (b == nb - 1);
            s.mod  = s.eop ? m : 3'd7;
            if (src == 0) q0.push_back(s);
            else          q1.push_back(s);
            if (b < n_exp) begin
                e     = s;
                e.mod = s.eop ? m : 3'd0;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic push_junk(input int src, input int n, input logic [7:0] tag);
        for (int b = 0; b < n; b++) begin
            beat_t s;
            s.data = 64'hDEAD_0000_0000_0000 | (64'(tag) << 16) | 64'(b);
            s.sop  = 1'b0;
            s.eop  = 1'b0;
            s.mod  = 3'd3;
            if (src == 0) q0.push_back(s);
            else          q1.push_back(s);
        end
    endtask

    task automatic drive_srcs();
        logic [N-1:0]    v;
        logic [N-1:0]    sp;
        logic [N-1:0]    ep;
        logic [3*N-1:0]  md;
        logic [64*N-1:0] dt;
        v = '0; sp = '0; ep = '0; md = '0; dt = '0;
        if (q0.size() > 0) begin
            v[0] = 1'b1; sp[0] = q0[0].sop; ep[0] = q0[0].eop;
            md[2:0] = q0[0].mod; dt[63:0] = q0[0].data;
        end
        if (q1.size() > 0) begin
            v[1] = 1'b1; sp[1] = q1[0].sop; ep[1] = q1[0].eop;
            md[5:3] = q1[0].mod; dt[127:64] = q1[0].data;
        end
        src_val = v; src_sop = sp; src_eop = ep; src_mod = md; src_data = dt;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || q0.size() != 0 || q1.size() != 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        total++;
        if (n >= budget) begin
            bad++;
            $display("FAIL drain_timeout: got %0d beats pending want 0",
                     exp_q.size() + q0.size() + q1.size());
        end
    endtask

    // Source driver: pop a beat after each handshake, present the next head.
    initial begin
        logic [N-1:0] hs;
        drive_srcs();
        forever begin
            @(negedge clk);
            hs = src_val & src_ready;
            @(posedge clk);
            #2;
            if (hs[0] && q0.size() > 0) q0.delete(0);
            if (hs[1] && q1.size() > 0) q1.delete(0);
            drive_srcs();
        end
    end

    // Monitor: scoreboard compare plus framing and back-pressure rules.
    initial begin
        beat_t e;
        logic  prev_full;
        logic  prev_eop;
        prev_full = 1'b0;
        prev_eop  = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_eop) chk("gap_after_eop", 64'(pkt_tx_val), 64'd0);
            if (prev_full) chk("val_after_full", 64'(pkt_tx_val), 64'd0);
            if (pkt_tx_full && cur_grant != '0) chk("ready_under_full", 64'(src_ready), 64'd0);
            if (pkt_tx_val) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: got data %0h want no beat", pkt_tx_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", pkt_tx_data, e.data);
                    chk("beat_sop", 64'(pkt_tx_sop), 64'(e.sop));
                    chk("beat_eop", 64'(pkt_tx_eop), 64'(e.eop));
                    chk("beat_mod", 64'(pkt_tx_mod), 64'(e.mod));
                end
            end
            prev_full = pkt_tx_full;
            prev_eop  = pkt_tx_val & pkt_tx_eop;
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n       = 1'b0;
        arb_en      = 1'b1;
        pkt_tx_full = 1'b0;
        s_val       = '0;
        s_sop       = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_val", 64'(pkt_tx_val), 64'd0);
        chk("rst_data", pkt_tx_data, 64'd0);
        chk("rst_grant", 64'(cur_grant), 64'd0);
        chk("rst_ready", 64'(src_ready), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Single 4-beat packet on source 0.
        @(posedge clk); #1;
        push_pkt(0, 4, 3'd5, 8'h01, 4);
        @(negedge clk);
        chk("t1_idle_grant", 64'(cur_grant), 64'd0);
        chk("t1_idle_ready", 64'(src_ready), 64'd0);
        @(negedge clk);
        chk("t1_grant", 64'(cur_grant), 64'b01);
        chk("t1_ready", 64'(src_ready), 64'b01);
        @(negedge clk);
        chk("t1_first_val", 64'(pkt_tx_val), 64'd1);
        chk("t1_first_sop", 64'(pkt_tx_sop), 64'd1);
        wait_drain(50);
        @(negedge clk);
        chk("t1_drop", 64'(drop_cnt), 64'd0);
        chk("t1_grant_end", 64'(cur_grant), 64'd0);

        // Fairness: last grant was 0, so source 1 leads and they alternate.
        @(posedge clk); #1;
        for (int p = 0; p < 3; p++) begin
            push_pkt(1, 3, 3'd2, 8'(8'h10 + p), 3);
            push_pkt(0, 3, 3'd6, 8'(8'h20 + p), 3);
        end
        wait_drain(100);

        // Back-pressure: full for 5 cycles in the middle of a 6-beat packet.
        @(posedge clk); #1;
        push_pkt(0, 6, 3'd1, 8'h30, 6);
        repeat (3) @(posedge clk);
        #1;
        pkt_tx_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_ready_low", 64'(src_ready), 64'd0);
            @(posedge clk); #1;
        end
        pkt_tx_full = 1'b0;
        @(negedge clk);
        chk("bp_ready_back", 64'(src_ready), 64'b01);
        wait_drain(50);

        // Malformed head: 3 non-SOP beats on source 1 are drained.
        @(posedge clk); #1;
        push_junk(1, 3, 8'h40);
        wait_drain(50);
        @(negedge clk);
        chk("junk_drop", 64'(drop_cnt), 64'd3);
        chk("junk_grant", 64'(cur_grant), 64'd0);

        // Saturation of a 2-bit drop counter after 5 drops.
        @(posedge clk); #1;
        s_val = 2'b10;
        s_sop = 2'b00;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("sat_drop_2", 64'(s_drop), 64'd2);
        repeat (3) @(posedge clk);
        #1;
        s_val = 2'b00;
        @(negedge clk);
        chk("sat_drop_3", 64'(s_drop), 64'd3);

        // arb_en dropped mid-packet: A completes, B and C wait, then RR picks 0.
        @(posedge clk); #1;
        push_pkt(1, 4, 3'd4, 8'h50, 4);
        push_pkt(0, 3, 3'd3, 8'h51, 3);
        push_pkt(1, 3, 3'd7, 8'h52, 3);
        repeat (2) @(posedge clk);
        #1;
        arb_en = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("dis_grant", 64'(cur_grant), 64'd0);
        chk("dis_pending", 64'(exp_q.size()), 64'd6);
        chk("dis_ready", 64'(src_ready), 64'd0);
        @(posedge clk); #1;
        arb_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("reen_grant", 64'(cur_grant), 64'b01);
        wait_drain(100);

        // Reset in the middle of a 6-beat packet on source 1.
        @(posedge clk); #1;
        push_pkt(1, 6, 3'd2, 8'h60, 2);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst2_val", 64'(pkt_tx_val), 64'd0);
        chk("rst2_sop", 64'(pkt_tx_sop), 64'd0);
        chk("rst2_eop", 64'(pkt_tx_eop), 64'd0);
        chk("rst2_data", pkt_tx_data, 64'd0);
        chk("rst2_mod", 64'(pkt_tx_mod), 64'd0);
        chk("rst2_grant", 64'(cur_grant), 64'd0);
        chk("rst2_drop", 64'(drop_cnt), 64'd0);
        wait_drain(50);
        @(negedge clk);
        chk("rst2_leftover_drop", 64'(drop_cnt), 64'd4);
        @(posedge clk); #1;
        push_pkt(0, 2, 3'd6, 8'h70, 2);
        push_pkt(1, 2, 3'd5, 8'h71, 2);
        @(negedge clk);
        @(negedge clk);
        chk("rst2_first_grant", 64'(cur_grant), 64'b01);
        wait_drain(50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
